// File: rtl/aurora_frame_pkg.sv
// Shared definitions for the 16-bit Aurora TX frame generator and RX frame capture.
package aurora_frame_pkg;

  // Default stream word width and frame length used by both ends of the link.
  localparam int DATA_W      = 16;
  localparam int FRAME_WORDS = 3;

  // Cause of the most recent bad frame, as reported to the control registers.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_KEEP  = 2'd3
  } err_code_e;

  // RX capture state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

endpackage : aurora_frame_pkg

// File: rtl/aurora_rx_frame_capture.sv
// Aurora RX frame capture: stages one frame of FRAME_WORDS words in a shadow
// buffer, checks length/tlast/tkeep framing, and publishes good frames with a
// done pulse. Bad frames raise an error pulse with a cause code. Both outcomes
// are tallied in saturating counters.
module aurora_rx_frame_capture
  import aurora_frame_pkg::*;
#(
  parameter int DATA_W      = aurora_frame_pkg::DATA_W,
  parameter int FRAME_WORDS = aurora_frame_pkg::FRAME_WORDS,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             i_rx_tdata,
  input  logic                          i_rx_tvalid,
  input  logic                          i_rx_tlast,
  input  logic [DATA_W/8-1:0]           i_rx_tkeep,
  input  logic                          i_arm,
  output logic [FRAME_WORDS*DATA_W-1:0] o_frame_data,
  output logic                          o_frame_done,
  output logic                          o_frame_err,
  output logic [1:0]                    o_err_code,
  output logic [CNT_W-1:0]              o_good_cnt,
  output logic [CNT_W-1:0]              o_bad_cnt,
  output logic                          o_busy
);

  // Beat position counter must be able to hold FRAME_WORDS itself.
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(FRAME_WORDS);

  // Counters stick at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rx_state_e                     r_state;
  rx_state_e                     w_state_next;
  logic [CW-1:0]                 r_count;
  logic                          r_keep_bad;
  logic [DATA_W-1:0]             r_shadow [FRAME_WORDS];

  logic                          w_accept;
  logic [CW-1:0]                 w_pos;
  logic                          w_keep_bad_any;
  logic                          w_good;
  logic                          w_bad;
  logic                          w_long;
  err_code_e                     w_err_code;
  logic [FRAME_WORDS*DATA_W-1:0] w_frame_next;

  // A beat belongs to a frame when it starts one (armed, in IDLE) or continues one.
  assign w_accept = i_rx_tvalid &&
                    (((r_state == ST_IDLE) && i_arm) || (r_state == ST_RECV));

  // 1-based position of the current beat within its frame.
  assign w_pos = (r_state == ST_RECV) ? (r_count + CW'(1)) : CW'(1);

  // Any partial-keep beat seen so far in this frame, including the current one.
  assign w_keep_bad_any = (i_rx_tkeep != '1) ||
                          ((r_state == ST_RECV) && r_keep_bad);

  // Classify the current beat: good completion, or which kind of bad frame.
  always_comb begin
    w_good     = 1'b0;
    w_bad      = 1'b0;
    w_long     = 1'b0;
    w_err_code = ERR_NONE;
    if (w_accept) begin
      if (i_rx_tlast) begin
        if (w_pos != LAST_POS) begin
          w_bad      = 1'b1;
          w_err_code = ERR_SHORT;
        end else if (w_keep_bad_any) begin
          w_bad      = 1'b1;
          w_err_code = ERR_KEEP;
        end else begin
          w_good = 1'b1;
        end
      end else if (w_pos == LAST_POS) begin
        w_bad      = 1'b1;
        w_long     = 1'b1;
        w_err_code = ERR_LONG;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode; arm only matters for starting a frame.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_RECV: begin
        if (w_accept) begin
          if (w_long)          w_state_next = ST_DROP;
          else if (i_rx_tlast) w_state_next = ST_IDLE;
          else                 w_state_next = ST_RECV;
        end
      end
      ST_DROP: begin
        if (i_rx_tvalid && i_rx_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State-derived output.
  always_comb begin
    o_busy = (r_state != ST_IDLE);
  end

  // Beat counter and sticky keep-error flag for the frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_keep_bad <= 1'b0;
    end else if (w_accept) begin
      r_count    <= (w_long || i_rx_tlast) ? '0 : w_pos;
      r_keep_bad <= w_keep_bad_any;
    end
  end

  // Shadow buffer holds words of the frame in progress; it is pure data.
  always_ff @(posedge clk) begin
    if (w_accept) r_shadow[w_pos - CW'(1)] <= i_rx_tdata;
  end

  // Complete frame image: earlier words from the shadow, the last word live.
  always_comb begin
    w_frame_next = '0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      w_frame_next[i*DATA_W +: DATA_W] =
        (i == FRAME_WORDS - 1) ? i_rx_tdata : r_shadow[i];
    end
  end

  // Publish results one cycle after the terminating beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_frame_data <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= ERR_NONE;
      o_good_cnt   <= '0;
      o_bad_cnt    <= '0;
    end else begin
      o_frame_done <= w_good;
      o_frame_err  <= w_bad;
      if (w_good) begin
        o_frame_data <= w_frame_next;
        o_good_cnt   <= sat_inc(o_good_cnt);
      end
      if (w_bad) begin
        o_err_code <= w_err_code;
        o_bad_cnt  <= sat_inc(o_bad_cnt);
      end
    end
  end

endmodule : aurora_rx_frame_capture

// File: tb/tb_aurora_rx_frame_capture.sv
// Bench for aurora_rx_frame_capture: directed framing cases followed by random
// traffic, compared every cycle against a frame-level reference model.
module tb_aurora_rx_frame_capture;

  localparam int DW  = 16;
  localparam int FW  = 3;
  localparam int CNW = 4;
  localparam int CNT_MAX = (1 << CNW) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DW-1:0]        rx_tdata;
  logic                 rx_tvalid;
  logic                 rx_tlast;
  logic [DW/8-1:0]      rx_tkeep;
  logic                 arm;
  logic [FW*DW-1:0]     frame_data;
  logic                 frame_done;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic [CNW-1:0]       good_cnt;
  logic [CNW-1:0]       bad_cnt;
  logic                 busy;

  always #5 clk = ~clk;

  aurora_rx_frame_capture #(
    .DATA_W(DW), .FRAME_WORDS(FW), .CNT_W(CNW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rx_tdata(rx_tdata), .i_rx_tvalid(rx_tvalid), .i_rx_tlast(rx_tlast),
    .i_rx_tkeep(rx_tkeep), .i_arm(arm),
    .o_frame_data(frame_data), .o_frame_done(frame_done), .o_frame_err(frame_err),
    .o_err_code(err_code), .o_good_cnt(good_cnt), .o_bad_cnt(bad_cnt), .o_busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for frame, 1 = collecting, 2 = discarding to tlast.
  int            m_mode;
  logic [DW-1:0] m_words [$];
  bit            m_keepbad;
  logic [FW*DW-1:0] m_frame;
  bit            m_done, m_err;
  logic [1:0]    m_code;
  int            m_good, m_bad;

  task automatic model_reset();
    m_mode = 0; m_words.delete(); m_keepbad = 0; m_frame = '0;
    m_done = 0; m_err = 0; m_code = 0; m_good = 0; m_bad = 0;
  endtask

  task automatic model_bad(input int code);
    m_err  = 1;
    m_code = 2'(code);
    if (m_bad < CNT_MAX) m_bad++;
  endtask

  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit l,
                            input logic [1:0] k, input bit a);
    m_done = 0;
    m_err  = 0;
    if (!v) return;
    if (m_mode == 2) begin
      if (l) m_mode = 0;
      return;
    end
    if (m_mode == 0) begin
      if (!a) return;
      m_mode = 1; m_words.delete(); m_keepbad = 0;
    end
    m_words.push_back(d);
    if (k != 2'b11) m_keepbad = 1;
    if (l) begin
      m_mode = 0;
      if (m_words.size() < FW) model_bad(1);
      else if (m_keepbad)      model_bad(3);
      else begin
        for (int i = 0; i < FW; i++) m_frame[i*DW +: DW] = m_words[i];
        m_done = 1;
        if (m_good < CNT_MAX) m_good++;
      end
    end else if (m_words.size() == FW) begin
      m_mode = 2;
      model_bad(2);
    end
  endtask

  task automatic check_all();
    check("done", 64'(frame_done), 64'(m_done));
    check("err",  64'(frame_err),  64'(m_err));
    check("code", 64'(err_code),   64'(m_code));
    check("data", 64'(frame_data), 64'(m_frame));
    check("good", 64'(good_cnt),   64'(m_good));
    check("bad",  64'(bad_cnt),    64'(m_bad));
    check("busy", 64'(busy),       64'(m_mode != 0));
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic beat(input bit v, input logic [DW-1:0] d, input bit l,
                      input logic [1:0] k, input bit a);
    rx_tvalid = v; rx_tdata = d; rx_tlast = l; rx_tkeep = k; arm = a;
    @(posedge clk);
    model_step(v, d, l, k, a);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0;
    @(posedge clk);
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 16'h0, 0, 2'b11, arm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rx_tdata = '0; rx_tvalid = 0; rx_tlast = 0; rx_tkeep = 2'b11; arm = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    do_reset();

    // Disarmed: a full frame is discarded.
    beat(1, 16'hAAAA, 0, 2'b11, 0);
    beat(1, 16'hBBBB, 0, 2'b11, 0);
    beat(1, 16'hCCCC, 1, 2'b11, 0);
    idle(2);
    check("disarm_good", 64'(good_cnt), 64'd0);

    // Good frame.
    beat(1, 16'h1111, 0, 2'b11, 1);
    beat(1, 16'h2222, 0, 2'b11, 1);
    beat(1, 16'h3333, 1, 2'b11, 1);
    check("t1_data", 64'(frame_data), 64'h333322221111);
    check("t1_done", 64'(frame_done), 64'd1);
    idle(1);

    // Short frame.
    beat(1, 16'h1111, 0, 2'b11, 1);
    beat(1, 16'h3333, 1, 2'b11, 1);
    check("short_code", 64'(err_code), 64'd1);
    idle(1);

    // Long frame, then a good frame.
    beat(1, 16'h4444, 0, 2'b11, 1);
    beat(1, 16'h5555, 0, 2'b11, 1);
    beat(1, 16'h6666, 0, 2'b11, 1);
    check("long_code", 64'(err_code), 64'd2);
    beat(1, 16'h7777, 1, 2'b11, 1);
    beat(1, 16'h0A0A, 0, 2'b11, 1);
    beat(1, 16'h0B0B, 0, 2'b11, 1);
    beat(1, 16'h0C0C, 1, 2'b11, 1);
    check("after_long", 64'(frame_data), 64'h0C0C0B0B0A0A);

    // Partial keep on beat 2.
    beat(1, 16'h1212, 0, 2'b11, 1);
    beat(1, 16'h3434, 0, 2'b01, 1);
    beat(1, 16'h5656, 1, 2'b11, 1);
    check("keep_code", 64'(err_code), 64'd3);
    idle(1);

    // Reset mid-frame, then a good frame.
    beat(1, 16'hDEAD, 0, 2'b11, 1);
    beat(1, 16'hBEEF, 0, 2'b11, 1);
    do_reset();
    beat(1, 16'h0101, 0, 2'b11, 1);
    beat(1, 16'h0202, 0, 2'b11, 1);
    beat(1, 16'h0303, 1, 2'b11, 1);

    // Back-to-back frames, valid gaps inside the second; arm drops mid-frame.
    beat(1, 16'h1001, 0, 2'b11, 1);
    beat(1, 16'h1002, 0, 2'b11, 1);
    beat(1, 16'h1003, 1, 2'b11, 1);
    beat(1, 16'h2001, 0, 2'b11, 1);
    beat(0, 16'hFFFF, 1, 2'b00, 0);
    beat(1, 16'h2002, 0, 2'b11, 0);
    beat(0, 16'hFFFF, 0, 2'b11, 0);
    beat(1, 16'h2003, 1, 2'b11, 0);
    check("b2b_good", 64'(good_cnt), 64'd3);
    idle(2);

    // Random traffic; small counters exercise saturation.
    for (int f = 0; f < 600; f++) begin
      int len;
      bit a;
      if ($urandom_range(0, 49) == 0) do_reset();
      len = $urandom_range(1, 5);
      a   = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 3) == 0)
          beat(0, 16'($urandom), 1'($urandom), 2'($urandom), a);
        beat(1, 16'($urandom), (b == len - 1),
             ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11,
             ($urandom_range(0, 9) == 0) ? ~a : a);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_aurora_rx_frame_capture
